fifo_sched: RTL and testbench

FIFO_SCHED -- requirements
Module: fifo_sched

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/fifo_sched.sv | 116 +++++++++++
 tb/tb_fifo_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types for the FIFO write scheduler and its pointer counters.
package fifo_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [3:0] counter_t;
  typedef logic [4:0] occ_t;
  typedef logic       req_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } sched_state_t;

  // Depth is one more than the wrap index, so it needs the wider occupancy type.
  function automatic occ_t depth_of(input nibble_t n);
    return {1'b0, n} + 5'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2
  import fifo_pkg::*;
#(
  parameter req_idx_t INIT_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic allow,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  req_idx_t last;

  always_comb begin
    gnt0 = allow && req0 && (!req1 || last == 1'b1);
    gnt1 = allow && req1 && (!req0 || last == 1'b0);
  end

  // Starting with the inverse of INIT_PRIO makes INIT_PRIO win the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= ~INIT_PRIO;
    end else if (gnt0) begin
      last <= 1'b0;
    end else if (gnt1) begin
      last <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_sched.sv
// fifo_sched: two-producer FIFO write scheduler with flush drain and occupancy tracking.
// Optional FIFO_SCHED_WM_EN adds registered almost_full/almost_empty watermarks.
module fifo_sched
  import fifo_pkg::*;
#(
  parameter req_idx_t INIT_PRIO = 1'b0
) (
  input  logic    clk,
  input  logic    rst,
  input  nibble_t N,
  input  logic    en,
  input  logic    flush,
  input  logic    req0,
  input  logic    req1,
  output logic    gnt0,
  output logic    gnt1,
  input  logic    pop_req,
  output logic    pop_ack,
  output logic    push,
  output logic    pop,
  output logic    wsel,
  output occ_t    count,
  output logic    empty,
  output logic    full
`ifdef FIFO_SCHED_WM_EN
  ,
  output logic    almost_full,
  output logic    almost_empty
`endif
);

  sched_state_t state;
  nibble_t      n_lat;
  occ_t         count_next;
  logic         wsel_q;

  assign empty = (count == 5'd0);
  assign full  = (count == depth_of(n_lat));

  rr_arb2 #(
    .INIT_PRIO(INIT_PRIO)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .allow(state == RUN && !full),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign push    = gnt0 | gnt1;
  assign pop_ack = (state == RUN) && pop_req && !empty;
  assign pop     = (state == RUN) ? pop_ack : ((state == FLUSH) && !empty);
  assign wsel    = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : wsel_q);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 5'd1;
    end else if (pop && !push) begin
      count_next = count - 5'd1;
    end
  end

  // FLUSH exits on the edge where the final pop empties the FIFO, or at once if already empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      n_lat  <= '0;
      count  <= '0;
      wsel_q <= 1'b0;
    end else begin
      count  <= count_next;
      wsel_q <= wsel;
      case (state)
        IDLE: begin
          if (en) begin
            state <= RUN;
            n_lat <= N;
          end
        end
        RUN: begin
          if (flush) begin
            state <= FLUSH;
          end else if (!en) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (count <= 5'd1) begin
            state <= en ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_SCHED_WM_EN
  nibble_t n_next;

  assign n_next = (state == IDLE && en) ? N : n_lat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_next >= {1'b0, n_next});
      almost_empty <= (count_next <= 5'd1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sched.sv
// tb_fifo_sched: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_fifo_sched;
  import fifo_pkg::*;

  localparam int MODE_IDLE  = 0;
  localparam int MODE_RUN   = 1;
  localparam int MODE_FLUSH = 2;

  logic    clk = 1'b0;
  logic    rst;
  nibble_t N;
  logic    en, flush, req0, req1, pop_req;
  logic    gnt0, gnt1, pop_ack, push, pop, wsel;
  occ_t    count;
  logic    empty, full;
`ifdef FIFO_SCHED_WM_EN
  logic    almost_full, almost_empty;
`endif

  int checks = 0;
  int errors = 0;

  int m_mode, m_count, m_nlat, m_last, m_wsel, m_af, m_ae;
  int e_g0, e_g1, e_pa, e_pop, e_wsel;

  fifo_sched #(
    .INIT_PRIO(1'b0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .N      (N),
    .en     (en),
    .flush  (flush),
    .req0   (req0),
    .req1   (req1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .pop_req(pop_req),
    .pop_ack(pop_ack),
    .push   (push),
    .pop    (pop),
    .wsel   (wsel),
    .count  (count),
    .empty  (empty),
    .full   (full)
`ifdef FIFO_SCHED_WM_EN
    ,
    .almost_full (almost_full),
    .almost_empty(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_mode  = MODE_IDLE;
    m_count = 0;
    m_nlat  = 0;
    m_last  = 1;
    m_wsel  = 0;
    m_af    = 0;
    m_ae    = 1;
  endtask

  // Expected strobes for this cycle from the current requests and the model state.
  task automatic predict();
    e_g0 = 0;
    e_g1 = 0;
    e_pa = 0;
    e_pop = 0;
    if (m_mode == MODE_RUN) begin
      if (m_count < m_nlat + 1) begin
        if (req0 && req1) begin
          if (m_last == 1) e_g0 = 1;
          else e_g1 = 1;
        end else begin
          e_g0 = int'(req0);
          e_g1 = int'(req1);
        end
      end
      e_pa  = (pop_req && m_count > 0) ? 1 : 0;
      e_pop = e_pa;
    end else if (m_mode == MODE_FLUSH) begin
      e_pop = (m_count > 0) ? 1 : 0;
    end
    e_wsel = (e_g1 == 1) ? 1 : ((e_g0 == 1) ? 0 : m_wsel);
  endtask

  task automatic checkAll();
    checkOutput("gnt0", int'(gnt0), e_g0);
    checkOutput("gnt1", int'(gnt1), e_g1);
    checkOutput("pop_ack", int'(pop_ack), e_pa);
    checkOutput("push", int'(push), e_g0 + e_g1);
    checkOutput("pop", int'(pop), e_pop);
    checkOutput("wsel", int'(wsel), e_wsel);
    checkOutput("count", int'(count), m_count);
    checkOutput("empty", int'(empty), (m_count == 0) ? 1 : 0);
    checkOutput("full", int'(full), (m_count == m_nlat + 1) ? 1 : 0);
`ifdef FIFO_SCHED_WM_EN
    checkOutput("almost_full", int'(almost_full), m_af);
    checkOutput("almost_empty", int'(almost_empty), m_ae);
`endif
  endtask

  task automatic advanceModel();
    m_count = m_count + e_g0 + e_g1 - e_pop;
    if (e_g0 == 1) m_last = 0;
    else if (e_g1 == 1) m_last = 1;
    m_wsel = e_wsel;
    case (m_mode)
      MODE_IDLE: begin
        if (en) begin
          m_mode = MODE_RUN;
          m_nlat = int'(N);
        end
      end
      MODE_RUN: begin
        if (flush) m_mode = MODE_FLUSH;
        else if (!en) m_mode = MODE_IDLE;
      end
      default: begin
        if (m_count == 0) m_mode = en ? MODE_RUN : MODE_IDLE;
      end
    endcase
    m_af = (m_count >= m_nlat) ? 1 : 0;
    m_ae = (m_count <= 1) ? 1 : 0;
  endtask

  // One clock cycle: drive at the falling edge, check mid-cycle, then follow the rising edge.
  task automatic applyStimulus(input logic e, input logic fl, input logic r0, input logic r1,
                               input logic pr, input int n);
    @(negedge clk);
    en      = e;
    flush   = fl;
    req0    = r0;
    req1    = r1;
    pop_req = pr;
    N       = nibble_t'(n);
    #1;
    predict();
    checkAll();
    @(posedge clk);
    advanceModel();
  endtask

  initial begin
    int lo;
    rst = 1'b0;
    N = 4'd3;
    en = 1'b0;
    flush = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    pop_req = 1'b0;
    modelReset();

    repeat (2) @(negedge clk);
    #1;
    predict();
    checkAll();
    checkOutput("reset_empty", int'(empty), 1);
    @(negedge clk);
    rst = 1'b1;

    // Fill to full with req0 alone, then drain.
    applyStimulus(1, 0, 0, 0, 0, 3);
    repeat (5) applyStimulus(1, 0, 1, 0, 0, 3);
    #1;
    checkOutput("fill_count", int'(count), 4);
    checkOutput("fill_full", int'(full), 1);
    repeat (4) applyStimulus(1, 0, 0, 0, 1, 3);
    #1;
    checkOutput("drain_empty", int'(empty), 1);

    // Pop on empty is ignored while the push goes through.
    applyStimulus(1, 0, 1, 0, 1, 3);
    applyStimulus(1, 0, 1, 0, 0, 3);

    // Tied requests alternate until full, then full with simultaneous push and pop.
    repeat (4) applyStimulus(1, 0, 1, 1, 0, 3);
    repeat (2) applyStimulus(1, 0, 0, 1, 1, 3);
    #1;
    checkOutput("fullpop_count", int'(count), 3);

    // Flush at count 3 drains over three cycles, requests blocked meanwhile.
    applyStimulus(1, 1, 0, 0, 0, 3);
    repeat (3) applyStimulus(1, 0, 1, 1, 1, 3);
    #1;
    checkOutput("flush_count", int'(count), 0);

    // Flush on an empty FIFO is a single bubble cycle.
    applyStimulus(1, 1, 0, 0, 0, 3);
    applyStimulus(1, 0, 0, 0, 0, 3);
    applyStimulus(1, 0, 1, 0, 0, 3);

    // Drop to IDLE, re-enter with a smaller N, then N changes in RUN are ignored.
    applyStimulus(0, 0, 1, 0, 0, 3);
    applyStimulus(0, 0, 1, 1, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 0, 7);
    applyStimulus(1, 0, 1, 1, 0, 7);
    #1;
    checkOutput("latched_full", int'(full), 1);

    // Reset in the middle of a flush at count 2.
    applyStimulus(1, 1, 0, 0, 0, 7);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    flush = 1'b0;
    #1;
    modelReset();
    predict();
    checkAll();
    checkOutput("midrst_count", int'(count), 0);
    checkOutput("midrst_empty", int'(empty), 1);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic; N is kept large enough that the latched depth covers the occupancy.
    for (int i = 0; i < 600; i++) begin
      lo = (m_count > 0) ? m_count - 1 : 0;
      if (lo > 15) lo = 15;
      applyStimulus(logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 23) == 0),
                    logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 1)), int'($urandom_range(15, lo)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
